// File: rtl/neighbor_fetch.sv
// neighbor_fetch: expands a vertex by reading its adjacency row, drops
// neighbors already in the visited bitmap, fetches coordinates of the
// rest and streams {id, coords} to the search core on valid/ready.
// Ports: clk_in/rst_in (sync, active high); node_in/node_valid_in/
// ready_out request side; clear_visited_in wipes bitmap in IDLE;
// adj_addr_out/adj_data_in and coord_addr_out/coord_data_in BRAM reads;
// vertex_id_out/vertex_out/vertex_valid_out/vertex_ready_in stream;
// done_out pulses at row end with count_out = neighbors emitted.
module neighbor_fetch #(
    parameter int DIM          = 2,
    parameter int MAX_DEG      = 8,
    parameter int NUM_VERTICES = 1024,
    parameter int ID_WIDTH     = 16,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [ID_WIDTH-1:0]   node_in,
    input  logic                  node_valid_in,
    input  logic                  clear_visited_in,
    output logic                  ready_out,
    output logic [ID_WIDTH+3:0]   adj_addr_out,
    input  logic [ID_WIDTH-1:0]   adj_data_in,
    output logic [ID_WIDTH-1:0]   coord_addr_out,
    input  logic [32*DIM-1:0]     coord_data_in,
    output logic [ID_WIDTH-1:0]   vertex_id_out,
    output logic [32*DIM-1:0]     vertex_out,
    output logic                  vertex_valid_out,
    input  logic                  vertex_ready_in,
    output logic                  done_out,
    output logic [7:0]            count_out
);

    localparam int AW = ID_WIDTH + 4;
    localparam int KW = $clog2(MAX_DEG + 1);
    localparam int VW = $clog2(NUM_VERTICES);
    localparam int CW = $clog2(BRAM_LATENCY + 1);

    localparam logic [AW-1:0]       STRIDE = AW'(MAX_DEG + 1);
    localparam logic [ID_WIDTH:0]   NV     = (ID_WIDTH + 1)'(NUM_VERTICES);
    localparam logic [ID_WIDTH-1:0] DMAX   = ID_WIDTH'(MAX_DEG);
    localparam logic [CW-1:0]       LAST   = CW'(BRAM_LATENCY - 1);
    localparam logic [CW-1:0]       FIN    = CW'(BRAM_LATENCY);

    typedef enum logic [2:0] {
        IDLE, RD_DEG, RD_NBR, CHECK, RD_COORD, EMIT, NEXT, DONE
    } state_t;

    state_t                  state;
    logic [AW-1:0]           row_base;
    logic [KW-1:0]           deg;
    logic [KW-1:0]           k;
    logic [ID_WIDTH-1:0]     nbr;
    logic [CW-1:0]           wait_cnt;
    logic [7:0]              count;
    logic [NUM_VERTICES-1:0] visited;

    logic [NUM_VERTICES-1:0] src_mask;
    logic [AW-1:0]           row_calc;

    function automatic logic in_range(input logic [ID_WIDTH-1:0] id);
        return {1'b0, id} < NV;
    endfunction

    // One-hot of the source vertex so clear-and-mark can happen in one write.
    always_comb begin
        src_mask = '0;
        if (in_range(node_in))
            src_mask[node_in[VW-1:0]] = 1'b1;
    end

    assign row_calc = AW'(node_in) * STRIDE;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            row_base         <= '0;
            deg              <= '0;
            k                <= '0;
            nbr              <= '0;
            wait_cnt         <= '0;
            count            <= '0;
            visited          <= '0;
            ready_out        <= 1'b1;
            adj_addr_out     <= '0;
            coord_addr_out   <= '0;
            vertex_id_out    <= '0;
            vertex_out       <= '0;
            vertex_valid_out <= 1'b0;
            done_out         <= 1'b0;
            count_out        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (node_valid_in) begin
                        if (clear_visited_in)
                            visited <= src_mask;
                        else
                            visited <= visited | src_mask;
                        row_base     <= row_calc;
                        adj_addr_out <= row_calc;
                        count        <= '0;
                        wait_cnt     <= '0;
                        ready_out    <= 1'b0;
                        state        <= RD_DEG;
                    end else if (clear_visited_in) begin
                        visited <= '0;
                    end
                end
                RD_DEG: begin
                    if (wait_cnt == LAST) begin
                        wait_cnt <= '0;
                        if (adj_data_in == '0) begin
                            done_out  <= 1'b1;
                            count_out <= count;
                            state     <= DONE;
                        end else begin
                            if (adj_data_in > DMAX)
                                deg <= KW'(MAX_DEG);
                            else
                                deg <= adj_data_in[KW-1:0];
                            k            <= KW'(1);
                            adj_addr_out <= row_base + AW'(1);
                            state        <= RD_NBR;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_NBR: begin
                    if (wait_cnt == LAST) begin
                        wait_cnt <= '0;
                        nbr      <= adj_data_in;
                        state    <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    // Out-of-range ids never touch the bitmap.
                    if (!in_range(nbr) || visited[nbr[VW-1:0]]) begin
                        state <= NEXT;
                    end else begin
                        visited[nbr[VW-1:0]] <= 1'b1;
                        coord_addr_out       <= nbr;
                        state                <= RD_COORD;
                    end
                end
                RD_COORD: begin
                    // Sample coords at the read latency, present them
                    // on the following cycle from the output register.
                    if (wait_cnt == FIN) begin
                        wait_cnt         <= '0;
                        vertex_id_out    <= nbr;
                        vertex_valid_out <= 1'b1;
                        state            <= EMIT;
                    end else begin
                        if (wait_cnt == LAST)
                            vertex_out <= coord_data_in;
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (vertex_ready_in) begin
                        vertex_valid_out <= 1'b0;
                        if (count != 8'hFF)
                            count <= count + 8'd1;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (k == deg) begin
                        done_out  <= 1'b1;
                        count_out <= count;
                        state     <= DONE;
                    end else begin
                        k            <= k + 1'b1;
                        adj_addr_out <= row_base + AW'(k) + AW'(1);
                        state        <= RD_NBR;
                    end
                end
                DONE: begin
                    done_out  <= 1'b0;
                    count_out <= '0;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
